// File: rtl/memory_instruction.sv
// rtl/memory_instruction.sv - 256x8 instruction memory with field split; MEMINST_PROG_EN enables the programming port
module memory_instruction (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] PCinst,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [2:0] OPCode,
    output logic [1:0] Rs,
    output logic [4:0] Four_Zero_Bits
);

    logic [7:0] instr;

`ifdef MEMINST_PROG_EN
    logic [7:0] mem [0:255];

    // Reset reloads the identity boot image; a write on the reset edge is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 8'(i);
            end
        end else if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        instr = mem[PCinst];
    end
`else
    // The boot image is the identity, so the ROM word is the address itself.
    logic unused_prog;
    assign unused_prog = ^{clock, prog_we, prog_addr, prog_data};

    always_comb begin
        instr = PCinst;
    end
`endif

    // Outputs read as a NOP word while reset is held.
    always_comb begin
        OPCode         = 3'b000;
        Rs             = 2'b00;
        Four_Zero_Bits = 5'b00000;
        if (!reset) begin
            OPCode         = instr[7:5];
            Rs             = instr[4:3];
            Four_Zero_Bits = instr[4:0];
        end
    end

endmodule

// File: tb/tb_memory_instruction.sv
// tb/tb_memory_instruction.sv - table and scoreboard checks of memory_instruction
module tb_memory_instruction;

    logic       clock;
    logic       reset;
    logic [7:0] PCinst;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic [2:0] OPCode;
    logic [1:0] Rs;
    logic [4:0] Four_Zero_Bits;

    memory_instruction dut (
        .clock          (clock),
        .reset          (reset),
        .PCinst         (PCinst),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .OPCode         (OPCode),
        .Rs             (Rs),
        .Four_Zero_Bits (Four_Zero_Bits)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] pc;
        logic [2:0] op;
        logic [1:0] rs;
        logic [4:0] fz;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    logic [7:0] model [0:255];

    function automatic logic [9:0] split(input logic [7:0] w);
        return {w[7:5], w[4:3], w[4:0]};
    endfunction

    task automatic expect_now(input string name, input logic [9:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
        #1;
        e = sbq.pop_front();
        checks++;
        if ({OPCode, Rs, Four_Zero_Bits} !== e.exp) begin
            errors++;
            $display("FAIL %s: got op=%b rs=%b fz=%b, expected op=%b rs=%b fz=%b",
                     e.name, OPCode, Rs, Four_Zero_Bits, e.exp[9:7], e.exp[6:5], e.exp[4:0]);
        end
    endtask

    task automatic model_boot();
        for (int a = 0; a < 256; a++) model[a] = 8'(a);
    endtask

    task automatic edge_write(input logic we, input logic [7:0] addr, input logic [7:0] data);
        prog_we   = we;
        prog_addr = addr;
        prog_data = data;
        @(posedge clock);
        #1;
        prog_we = 1'b0;
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{8'h00,       3'b000, 2'b00, 5'b00000};
        vecs[1] = '{8'b10000001, 3'b100, 2'b00, 5'b00001};
        vecs[2] = '{8'b00010010, 3'b000, 2'b10, 5'b10010};
        vecs[3] = '{8'b00001011, 3'b000, 2'b01, 5'b01011};
        vecs[4] = '{8'b00000100, 3'b000, 2'b00, 5'b00100};
        vecs[5] = '{8'hFF,       3'b111, 2'b11, 5'b11111};
        vecs[6] = '{8'hE7,       3'b111, 2'b00, 5'b00111};

        reset     = 1'b1;
        PCinst    = 8'hE7;
        prog_we   = 1'b0;
        prog_addr = 8'h00;
        prog_data = 8'h00;
        model_boot();
        expect_now("reset_state", 10'b0);
        @(negedge clock);
        reset = 1'b0;
        expect_now("reset_release_e7", {3'b111, 2'b00, 5'b00111});

        for (int i = 0; i < 7; i++) begin
            PCinst = vecs[i].pc;
            expect_now($sformatf("vec%0d_pc%02h", i, vecs[i].pc),
                       {vecs[i].op, vecs[i].rs, vecs[i].fz});
        end

        for (int a = 0; a < 256; a++) begin
            PCinst = 8'(a);
            #1;
            checks++;
            if ({OPCode, Rs, Four_Zero_Bits} !== split(model[a])) begin
                errors++;
                $display("FAIL boot_sweep_%02h: got %b, expected %b",
                         a[7:0], {OPCode, Rs, Four_Zero_Bits}, split(model[a]));
            end
        end

        // Asynchronous reset assertion between clock edges
        @(negedge clock);
        PCinst = 8'hE7;
        #2;
        reset = 1'b1;
        expect_now("async_reset_zero", 10'b0);
        reset = 1'b0;
        expect_now("async_release_e7", {3'b111, 2'b00, 5'b00111});

`ifdef MEMINST_PROG_EN
        @(negedge clock);
        PCinst    = 8'h05;
        prog_we   = 1'b1;
        prog_addr = 8'h05;
        prog_data = 8'hA9;
        expect_now("prog_before_edge", {3'b000, 2'b00, 5'b00101});
        @(posedge clock);
        model[8'h05] = 8'hA9;
        expect_now("prog_after_edge", {3'b101, 2'b01, 5'b01001});
        prog_we = 1'b0;

        @(negedge clock);
        edge_write(1'b0, 8'h05, 8'h33);
        expect_now("prog_we0_nochange", split(model[8'h05]));

        @(negedge clock);
        edge_write(1'b1, 8'hF0, 8'h1C);
        model[8'hF0] = 8'h1C;
        PCinst = 8'hF0;
        expect_now("prog_other_addr", {3'b000, 2'b11, 5'b11100});
        PCinst = 8'h05;
        expect_now("prog_neighbour_kept", {3'b101, 2'b01, 5'b01001});

        @(negedge clock);
        reset = 1'b1;
        model_boot();
        expect_now("midprog_reset_zero", 10'b0);
        edge_write(1'b1, 8'h05, 8'h77);
        @(negedge clock);
        reset = 1'b0;
        expect_now("midprog_restored_05", {3'b000, 2'b00, 5'b00101});
        PCinst = 8'hF0;
        expect_now("midprog_restored_f0", {3'b111, 2'b10, 5'b10000});

        @(negedge clock);
        edge_write(1'b1, 8'h80, 8'h00);
        PCinst = 8'h80;
        expect_now("first_write_after_reset", 10'b0);
`else
        @(negedge clock);
        edge_write(1'b1, 8'h80, 8'h00);
        PCinst = 8'h80;
        expect_now("rom_write_ignored_80", {3'b100, 2'b00, 5'b00000});
        @(negedge clock);
        edge_write(1'b1, 8'h05, 8'hA9);
        PCinst = 8'h05;
        expect_now("rom_write_ignored_05", {3'b000, 2'b00, 5'b00101});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
